// File: rtl/button_pkg.sv
// Shared definitions for the button event classifier: state encoding,
// classification event bundle and timer sizing.
package button_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    GAP       = 3'd3,
    SECOND    = 3'd4
  } state_t;

  typedef struct packed {
    logic shortPress;
    logic longPress;
    logic doubleClick;
  } classEv_t;

  // One spare bit above clog2 so the saturation ceiling sits beyond every compare value.
  function automatic int timerWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Level edge detector: combinational rise/fall against the previous sample,
// plus registered one-cycle copies of each.
module button_edge_detect (
  input  logic clkIn,
  input  logic rstIn,
  input  logic levelIn,
  output logic rise,
  output logic fall,
  output logic risePulse,
  output logic fallPulse
);

  logic levelPrev;

  assign rise = levelIn & ~levelPrev;
  assign fall = ~levelIn & levelPrev;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      levelPrev <= 1'b0;
      risePulse <= 1'b0;
      fallPulse <= 1'b0;
    end else begin
      levelPrev <= levelIn;
      risePulse <= rise;
      fallPulse <= fall;
    end
  end

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into press/release/short/long/double pulses.
// Optional auto-repeat while held past a long press: define BUTTON_AUTO_REPEAT_EN.
module button_event_classifier
  import button_pkg::*;
#(
  parameter int LONG_CNT       = 50000000,
  parameter int DCLICK_GAP_CNT = 12500000,
  parameter int REPEAT_CNT     = 5000000
) (
  input  logic               clkIn,
  input  logic               rstIn,
  input  logic               buttonIn,
  output logic               pressOut,
  output logic               releaseOut,
  output logic               shortPressOut,
  output logic               longPressOut,
  output logic               doubleClickOut,
  output logic               repeatOut,
  output logic [STATE_W-1:0] stateOut
);

  localparam int TW = timerWidth(LONG_CNT, DCLICK_GAP_CNT, REPEAT_CNT);

  state_t          state, stateNxt;
  logic [TW-1:0]   timer, timerNxt, timerInc;
  classEv_t        ev, evNxt;
  logic            rise, fall;
  logic            longHit, gapHit;

  button_edge_detect uEdge (
    .clkIn     (clkIn),
    .rstIn     (rstIn),
    .levelIn   (buttonIn),
    .rise      (rise),
    .fall      (fall),
    .risePulse (pressOut),
    .fallPulse (releaseOut)
  );

  assign longHit  = (timer == TW'(LONG_CNT - 1));
  assign gapHit   = (timer == TW'(DCLICK_GAP_CNT - 1));
  assign timerInc = (timer == '1) ? timer : timer + 1'b1;

`ifdef BUTTON_AUTO_REPEAT_EN
  logic repeatHit, repeatNxt, repeatQ;
  assign repeatHit = (timer == TW'(REPEAT_CNT - 1));
  // A release on the repeat cycle ends the hold, so it suppresses that pulse.
  assign repeatNxt = (state == LONG_HELD) && !fall && repeatHit;
  assign repeatOut = repeatQ;
`else
  assign repeatOut = 1'b0;
`endif

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state <= IDLE;
      timer <= '0;
      ev    <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
      repeatQ <= 1'b0;
`endif
    end else begin
      state <= stateNxt;
      timer <= timerNxt;
      ev    <= evNxt;
`ifdef BUTTON_AUTO_REPEAT_EN
      repeatQ <= repeatNxt;
`endif
    end
  end

  // A release landing on the long-press cycle means the button was not held,
  // so fall takes priority over the long-press compare.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:      if (rise) stateNxt = PRESSED;
      PRESSED:   if (fall) stateNxt = GAP;
                 else if (longHit) stateNxt = LONG_HELD;
      LONG_HELD: if (fall) stateNxt = IDLE;
      GAP:       if (rise) stateNxt = SECOND;
                 else if (gapHit) stateNxt = IDLE;
      SECOND:    if (fall) stateNxt = IDLE;
                 else if (longHit) stateNxt = LONG_HELD;
      default:   stateNxt = IDLE;
    endcase
  end

  always_comb begin
    timerNxt = timer;
    if (stateNxt != state)
      timerNxt = '0;
    else if (state == PRESSED || state == GAP || state == SECOND)
      timerNxt = timerInc;
`ifdef BUTTON_AUTO_REPEAT_EN
    else if (state == LONG_HELD)
      timerNxt = repeatHit ? '0 : timerInc;
`endif
  end

  always_comb begin
    evNxt = '0;
    case (state)
      PRESSED: evNxt.longPress = !fall && longHit;
      GAP:     evNxt.shortPress = !rise && gapHit;
      SECOND: begin
        evNxt.doubleClick = fall;
        evNxt.longPress   = !fall && longHit;
      end
      default: evNxt = '0;
    endcase
  end

  assign shortPressOut  = ev.shortPress;
  assign longPressOut   = ev.longPress;
  assign doubleClickOut = ev.doubleClick;
  assign stateOut       = state;

endmodule
